// File: rtl/shift_pla_inv.sv
// Sequential piecewise-linear artanh: inverts the shift-only tanh PLA by scanning
// the leading ones of |y| one bit per clock, then rebuilding x from shifts only.
module shift_pla_inv #(
    parameter int W_IN  = 8,
    parameter int W_OUT = 8,
    parameter int OUT_I = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out
);

    localparam int F     = W_IN - 1;
    localparam int OUT_F = W_OUT - OUT_I;
    localparam int KW    = $clog2(F + 1);
    localparam int RW    = F + OUT_F;
    localparam int XW    = RW + KW + W_OUT;

    localparam logic [W_IN-1:0]  Y_MIN = {1'b1, {(W_IN-1){1'b0}}};
    localparam logic [W_OUT-1:0] X_MAX = {1'b0, {(W_OUT-1){1'b1}}};
    localparam logic [W_OUT-1:0] X_MIN = {1'b1, {(W_OUT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, BUILD, DONE} state_t;

    state_t          state;
    logic [F-1:0]    sr;
    logic [KW-1:0]   k;
    logic            neg;
    logic            neg_full;

    logic [W_IN-1:0]  y_mag;
    logic [RW-1:0]    rem;
    logic [XW-1:0]    x_pos;
    logic [W_OUT-1:0] mag;
    logic [W_OUT-1:0] result;

    assign in_ready = (state == IDLE);

    // x_pos in units of 2^-OUT_F: k/2 becomes k << (OUT_F-1), the remainder
    // bits b_{k+2}.. fill the fraction below x^-1, truncated past OUT_F.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        y_mag  = in[F] ? -in : in;
        rem    = {sr, {OUT_F{1'b0}}} >> (F + 1);
        x_pos  = (XW'(k) << (OUT_F - 1)) | XW'(rem);
        mag    = (x_pos > XW'(X_MAX)) ? X_MAX : x_pos[W_OUT-1:0];
        if (neg_full)
            result = X_MIN;
        else if (neg)
            result = -mag;
        else
            result = mag;
    end

    // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            sr        <= '0;
            k         <= '0;
            neg       <= 1'b0;
            neg_full  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sr       <= y_mag[F-1:0];
                        neg      <= in[F];
                        neg_full <= (in == Y_MIN);
                        k        <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    sr <= sr << 1;
                    if (sr[F-1]) begin
                        k <= k + 1'b1;
                        if (k == KW'(F - 1))
                            state <= BUILD;
                    end else begin
                        state <= BUILD;
                    end
                end
                BUILD: begin
                    out       <= result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_pla_inv.sv
// Scoreboard bench: two instances (Q4.4 and saturating Q2.6 outputs) share stimulus;
// the driver queues hand-computed results, a negedge monitor pops and compares.
module tb_shift_pla_inv;

    logic       clock = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] y;
    logic       out_ready;
    logic       in_ready, in_ready2;
    logic       out_valid, out_valid2;
    logic [7:0] out1, out2;

    always #5 clock = ~clock;

    shift_pla_inv #(.W_IN(8), .W_OUT(8), .OUT_I(4)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in(y), .out_valid(out_valid), .out_ready(out_ready), .out(out1)
    );

    shift_pla_inv #(.W_IN(8), .W_OUT(8), .OUT_I(2)) dut2 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
        .in(y), .out_valid(out_valid2), .out_ready(out_ready), .out(out2)
    );

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e2;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latch the output at the rising edge of out_valid, require it to
    // stay put under backpressure, and score it when the handshake happens.
    logic       prev_valid = 1'b0;
    int         rise_cyc = 0;
    logic [7:0] hold1, hold2;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_valid = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!prev_valid) begin
                    rise_cyc = cyc;
                    hold1    = out1;
                    hold2    = out2;
                end else begin
                    check("out_stable", 32'(out1), 32'(hold1));
                end
                if (out_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_q44", 32'(out1), 32'(e.e1));
                    check("valid_q26", 32'(out_valid2), 32'd1);
                    check("out_q26", 32'(out2), 32'(e.e2));
                    check("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic accept(input logic [7:0] v, input logic [7:0] e1, input logic [7:0] e2,
                          input int lat);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clock); #1;
        y        = v;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        e.e1 = e1; e.e2 = e2; e.lat = lat; e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (q.size() == 0) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // y, expected Q4.4, expected Q2.6, clocks from accept to out_valid
    localparam int NV = 12;
    logic [7:0] vy  [NV] = '{8'h20, 8'h58, 8'hA8, 8'h80, 8'h7F, 8'h7C,
                            8'h00, 8'h81, 8'h40, 8'h6A, 8'hFF, 8'h7E};
    logic [7:0] ve1 [NV] = '{8'h04, 8'h0E, 8'hF2, 8'h80, 8'h38, 8'h28,
                            8'h00, 8'hC8, 8'h08, 8'h15, 8'h00, 8'h30};
    logic [7:0] ve2 [NV] = '{8'h10, 8'h38, 8'hC8, 8'h80, 8'h7F, 8'h7F,
                            8'h00, 8'h81, 8'h20, 8'h54, 8'h00, 8'h7F};
    int         vlat[NV] = '{2, 3, 3, 2, 8, 7, 2, 8, 3, 4, 2, 8};

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        y         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", 32'(out1), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            accept(vy[i], ve1[i], ve2[i], vlat[i]);
            wait_drain();
        end

        // Backpressure: hold the result for 10 cycles while poking in_valid.
        out_ready = 1'b0;
        accept(8'h58, 8'h0E, 8'h38, 3);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clock);
                if (out_valid) ok = 1'b1;
            end
            if (!ok) check("bp_valid_timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            y        = 8'h7F;
            in_valid = i[0];
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        check("bp_queue_empty", 32'(q.size()), 32'd0);
        repeat (12) @(posedge clock);

        // Reset during SCAN aborts the sample.
        accept(8'h7F, 8'h38, 8'h7F, 8);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b0;
        void'(q.pop_back());
        @(posedge clock); #1;
        resetn = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out", 32'(out1), 32'd0);
        repeat (12) @(posedge clock);
        accept(8'h20, 8'h04, 8'h10, 2);
        wait_drain();
        repeat (3) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
